dmem_mmio_responder: RTL and testbench
======================================

// Module: dmem_mmio_responder
// PURPOSE
//  Responder for the pipeline's M-stage data-memory port (MemWriteM/ALUResultM/WriteDataM -> ReadDataM).
//  Decodes byte address into word RAM or memory-mapped I/O: GPIO output register, free-running timer
//  with compare/sticky flag, and a TX byte FIFO drained over a valid/ready egress. Sits beside the core top.
// PARAMETERS
//  RAM_WORDS   256          RAM depth in 32-bit words (power of 2)
//  MMIO_BASE   32'h8000_0000  base of MMIO window (4 KiB, decoded on ALUResultM[31:12])
//  GPIO_W      8            width of GpioOut
//  TX_DEPTH    4            TX FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  reset       in   1       synchronous, ACTIVE-LOW; sampled on clk rising edge
//  MemWriteM   in   1       store strobe for current M-stage access
//  ALUResultM  in   32      byte address; bits[1:0] ignored (word accesses only)
//  WriteDataM  in   32      store data
//  ReadDataM   out  32      load data, combinational from ALUResultM (same cycle)
//  GpioOut     out  GPIO_W  GPIO register value
//  TimerIrq    out  1       = STATUS.timer_hit
//  TxData      out  8       FIFO head byte
//  TxValid     out  1       FIFO non-empty
//  TxReady     in   1       consumer accepts head when TxValid&&TxReady at clk edge
// BEHAVIOUR
//  Map: RAM at 0 .. 4*RAM_WORDS-1, index = ALUResultM[log2(RAM_WORDS)+1:2]. MMIO offsets:
//   0x00 GPIO (RW, low GPIO_W bits)  0x04 TCOUNT (RW)  0x08 TCMP (RW)  0x10 TXDATA (WO, byte [7:0])
//   0x0C STATUS (R): [0] timer_hit [1] tx_full [2] tx_empty [3] tx_overflow [7:4] tx_count; W1C on [0],[3].
//  Unmapped reads return 0; unmapped/RO-field writes ignored. TXDATA reads return 0.
//  Reads: purely combinational, reflect pre-edge state (a same-cycle store is not visible until next cycle).
//  Writes: take effect at the rising edge where MemWriteM=1.
//  Reset (reset==0 at edge): GPIO=0, TCOUNT=0, TCMP=32'hFFFF_FFFF, timer_hit=0, tx_overflow=0, FIFO
//   emptied (TxValid=0, TxData=0). RAM contents NOT reset. Reset mid-transfer discards queued bytes.
//  Timer: TCOUNT += 1 every cycle, wraps 2^32-1 -> 0. Store to TCOUNT overrides increment that edge.
//   When TCOUNT==TCMP (pre-edge), timer_hit set at that edge; sticky. Set and W1C same edge: set wins.
//  FIFO: push on store to TXDATA; pop when TxValid&&TxReady. Push accepted iff !full or pop same edge
//   (count unchanged on simultaneous push+pop). Rejected push sets tx_overflow (sticky, W1C; set wins).
//   Push on empty: TxValid rises next cycle (1-cycle latency). TxData stable while TxValid&&!TxReady.
//   Pointers wrap modulo TX_DEPTH; count range 0..TX_DEPTH.
// STRUCTURE
//  Shared pkg riscv_mem_pkg: MMIO offset constants, STATUS bit indices, MMIO_BASE default.
//  One sub-module: tx_fifo (sync FIFO, push/pop/full/empty/count, active-low sync reset).
//  Top: address decode, RAM array, GPIO/timer/status regs, read mux.
// TESTING
//  1 Store 0xDEADBEEF @0x40, load @0x40 next cycle -> 0xDEADBEEF; load @0x43 -> same word.
//  2 Store GPIO 0x1A5 (GPIO_W=8) -> GpioOut=0xA5 next cycle; reset low one edge -> GpioOut=0.
//  3 TCMP=10, TCOUNT=5 -> TimerIrq=1 from edge after count 10; W1C STATUS bit0 -> 0; TCOUNT=0xFFFFFFFF wraps to 0.
//  4 TxReady=0, push 5 bytes 0x11..0x15 -> tx_full=1, tx_overflow=1, count=4; TxData=0x11 held stable.
//  5 Full FIFO, push 0x99 with TxReady=1 same edge -> accepted, no overflow, count stays 4, order 0x12..0x99.
//  6 Read unmapped 0x8000_0100 -> 0; reset asserted with 3 queued bytes -> TxValid=0 next cycle, count=0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the M-stage data-memory responder.
// Covers the MMIO register offsets, the STATUS bit positions and the access-select decode.
package riscv_mem_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [11:0] OFF_GPIO   = 12'h000;
  localparam logic [11:0] OFF_TCOUNT = 12'h004;
  localparam logic [11:0] OFF_TCMP   = 12'h008;
  localparam logic [11:0] OFF_STATUS = 12'h00C;
  localparam logic [11:0] OFF_TXDATA = 12'h010;

  localparam int ST_TIMER_HIT    = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_TX_OVERFLOW  = 3;
  localparam int ST_TX_COUNT_LSB = 4;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO,
    SEL_TCOUNT,
    SEL_TCMP,
    SEL_STATUS,
    SEL_TXDATA
  } accessSel_e;

  // Word-granular decode: byte-lane bits of the offset never select a register.
  function automatic accessSel_e mmioSel(input logic [11:0] offset);
    accessSel_e sel;
    case ({offset[11:2], 2'b00})
      OFF_GPIO:   sel = SEL_GPIO;
      OFF_TCOUNT: sel = SEL_TCOUNT;
      OFF_TCMP:   sel = SEL_TCMP;
      OFF_STATUS: sel = SEL_STATUS;
      OFF_TXDATA: sel = SEL_TXDATA;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Synchronous byte FIFO feeding the TX egress.
// A push into a full FIFO is still accepted when a pop happens on the same edge.
import riscv_mem_pkg::*;

module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pushDropped
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W:0]    cnt;
  logic              doPush;
  logic              doPop;

  assign empty       = (cnt == '0);
  assign full        = (cnt == (PTR_W+1)'(DEPTH));
  assign count       = cnt;
  assign doPop       = pop && !empty;
  assign doPush      = push && (!full || doPop);
  assign pushDropped = push && !doPush;
  assign head        = empty ? '0 : mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the M stage: word RAM plus a small MMIO window
// (GPIO, free-running timer with compare flag, TX byte FIFO with valid/ready egress).
import riscv_mem_pkg::*;

module dmem_mmio_responder #(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter int          GPIO_W    = 8,
  parameter int          TX_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic [GPIO_W-1:0] GpioOut,
  output logic              TimerIrq,
  output logic [7:0]        TxData,
  output logic              TxValid,
  input  logic              TxReady
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CNT_W  = $clog2(TX_DEPTH) + 1;

  logic [31:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0] ramIdx;
  accessSel_e        sel;
  logic              isRam;
  logic              isMmio;

  logic [GPIO_W-1:0] gpioReg;
  logic [31:0]       tCount;
  logic [31:0]       tCmp;
  logic              timerHit;
  logic              txOverflow;
  logic [31:0]       status;

  logic              txPush;
  logic              txPop;
  logic              txFull;
  logic              txEmpty;
  logic [CNT_W-1:0]  txCount;
  logic              txDropped;

  logic              wrGpio;
  logic              wrTcount;
  logic              wrTcmp;
  logic              wrStatus;

  assign ramIdx = ALUResultM[RAM_AW+1:2];
  assign isRam  = (ALUResultM[31:RAM_AW+2] == '0);
  assign isMmio = (ALUResultM[31:12] == MMIO_BASE[31:12]);

  always_comb begin
    sel = SEL_NONE;
    if (isRam)       sel = SEL_RAM;
    else if (isMmio) sel = mmioSel(ALUResultM[11:0]);
  end

  assign wrGpio   = MemWriteM && (sel == SEL_GPIO);
  assign wrTcount = MemWriteM && (sel == SEL_TCOUNT);
  assign wrTcmp   = MemWriteM && (sel == SEL_TCMP);
  assign wrStatus = MemWriteM && (sel == SEL_STATUS);
  assign txPush   = MemWriteM && (sel == SEL_TXDATA);
  assign txPop    = TxValid && TxReady;

  tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_txFifo (
    .clk         (clk),
    .reset       (reset),
    .push        (txPush),
    .pushData    (WriteDataM[7:0]),
    .pop         (txPop),
    .head        (TxData),
    .full        (txFull),
    .empty       (txEmpty),
    .count       (txCount),
    .pushDropped (txDropped)
  );

  assign TxValid  = !txEmpty;
  assign GpioOut  = gpioReg;
  assign TimerIrq = timerHit;

  // RAM is deliberately left out of reset so software state survives a core reset.
  always_ff @(posedge clk) begin
    if (MemWriteM && sel == SEL_RAM) ram[ramIdx] <= WriteDataM;
  end

  // Sticky flags: a set condition on the same edge as a W1C store takes priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gpioReg    <= '0;
      tCount     <= '0;
      tCmp       <= 32'hFFFF_FFFF;
      timerHit   <= 1'b0;
      txOverflow <= 1'b0;
    end else begin
      if (wrGpio) gpioReg <= WriteDataM[GPIO_W-1:0];
      if (wrTcmp) tCmp    <= WriteDataM;
      tCount <= wrTcount ? WriteDataM : tCount + 32'd1;

      if (tCount == tCmp)
        timerHit <= 1'b1;
      else if (wrStatus && WriteDataM[ST_TIMER_HIT])
        timerHit <= 1'b0;

      if (txDropped)
        txOverflow <= 1'b1;
      else if (wrStatus && WriteDataM[ST_TX_OVERFLOW])
        txOverflow <= 1'b0;
    end
  end

  always_comb begin
    status = '0;
    status[ST_TIMER_HIT]   = timerHit;
    status[ST_TX_FULL]     = txFull;
    status[ST_TX_EMPTY]    = txEmpty;
    status[ST_TX_OVERFLOW] = txOverflow;
    status[ST_TX_COUNT_LSB +: 4] = 4'(txCount);
  end

  always_comb begin
    ReadDataM = '0;
    case (sel)
      SEL_RAM:    ReadDataM = ram[ramIdx];
      SEL_GPIO:   ReadDataM = 32'(gpioReg);
      SEL_TCOUNT: ReadDataM = tCount;
      SEL_TCMP:   ReadDataM = tCmp;
      SEL_STATUS: ReadDataM = status;
      default:    ReadDataM = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: a vector table for RAM/GPIO/decode
// plus hand-written timer, FIFO and reset sequences.
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_GPIO   = 32'h8000_0000;
  localparam logic [31:0] A_TCOUNT = 32'h8000_0004;
  localparam logic [31:0] A_TCMP   = 32'h8000_0008;
  localparam logic [31:0] A_STATUS = 32'h8000_000C;
  localparam logic [31:0] A_TXDATA = 32'h8000_0010;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic [7:0]  GpioOut;
  logic        TimerIrq;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRead;
    string       name;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] drainExp[4];

  dmem_mmio_responder dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .GpioOut    (GpioOut),
    .TimerIrq   (TimerIrq),
    .TxData     (TxData),
    .TxValid    (TxValid),
    .TxReady    (TxReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    MemWriteM  = we;
    ALUResultM = addr;
    WriteDataM = wdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic storeWord(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data);
    tick();
    applyStimulus(1'b0, addr, 32'h0);
  endtask

  task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] expected);
    applyStimulus(1'b0, addr, 32'h0);
    #1;
    checkOutput(name, ReadDataM, expected);
  endtask

  initial begin
    reset   = 1'b0;
    TxReady = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);

    vecs.push_back('{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, "st40"});
    vecs.push_back('{1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, "ld40"});
    vecs.push_back('{1'b0, 32'h0000_0043, 32'h0, 32'hDEAD_BEEF, "ld43"});
    vecs.push_back('{1'b1, 32'h0000_0044, 32'h1234_5678, 32'h0, "st44"});
    vecs.push_back('{1'b0, 32'h0000_0044, 32'h0, 32'h1234_5678, "ld44"});
    vecs.push_back('{1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, "ld40again"});
    vecs.push_back('{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0, "stLast"});
    vecs.push_back('{1'b0, 32'h0000_03FE, 32'h0, 32'hCAFE_F00D, "ldLast"});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0, "st0"});
    vecs.push_back('{1'b1, 32'h0000_0400, 32'h0000_0BAD, 32'h0, "stBeyondRam"});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, "ldNoAlias"});
    vecs.push_back('{1'b0, 32'h0000_0400, 32'h0, 32'h0000_0000, "ldBeyondRam"});
    vecs.push_back('{1'b1, A_GPIO, 32'h0000_01A5, 32'h0, "stGpio"});
    vecs.push_back('{1'b0, A_GPIO, 32'h0, 32'h0000_00A5, "ldGpio"});
    vecs.push_back('{1'b0, 32'h8000_0100, 32'h0, 32'h0, "ldUnmapped"});
    vecs.push_back('{1'b0, A_TXDATA, 32'h0, 32'h0, "ldTxdata"});
    vecs.push_back('{1'b0, A_STATUS, 32'h0, 32'h0000_0004, "ldStatusIdle"});
    vecs.push_back('{1'b0, 32'h8001_0000, 32'h0, 32'h0, "ldOutsideWindow"});

    tick();
    tick();
    checkOutput("rstGpio", 32'(GpioOut), 32'h0);
    checkOutput("rstIrq", 32'(TimerIrq), 32'h0);
    checkOutput("rstTxValid", 32'(TxValid), 32'h0);
    checkOutput("rstTxData", 32'(TxData), 32'h0);
    readCheck("rstTcount", A_TCOUNT, 32'h0);
    readCheck("rstTcmp", A_TCMP, 32'hFFFF_FFFF);
    readCheck("rstStatus", A_STATUS, 32'h0000_0004);
    reset = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      #1;
      if (!vecs[i].we) checkOutput(vecs[i].name, ReadDataM, vecs[i].expRead);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0);

    // GPIO survives normal operation and clears on a single reset edge.
    checkOutput("gpioOut", 32'(GpioOut), 32'h0000_00A5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("gpioAfterReset", 32'(GpioOut), 32'h0);
    readCheck("ramKeptOverReset", 32'h0000_0040, 32'hDEAD_BEEF);

    // Timer compare, sticky flag, W1C and set-wins-over-clear.
    storeWord(A_TCMP, 32'd10);
    storeWord(A_TCOUNT, 32'd5);
    readCheck("tcountLoaded", A_TCOUNT, 32'd5);
    repeat (5) tick();
    readCheck("tcountAt10", A_TCOUNT, 32'd10);
    checkOutput("irqBeforeHit", 32'(TimerIrq), 32'h0);
    tick();
    checkOutput("irqAfterHit", 32'(TimerIrq), 32'h1);
    tick();
    checkOutput("irqSticky", 32'(TimerIrq), 32'h1);
    storeWord(A_STATUS, 32'h1);
    checkOutput("irqW1C", 32'(TimerIrq), 32'h0);
    storeWord(A_TCOUNT, 32'd10);
    storeWord(A_STATUS, 32'h1);
    checkOutput("irqSetWins", 32'(TimerIrq), 32'h1);
    storeWord(A_STATUS, 32'h1);
    checkOutput("irqClearAgain", 32'(TimerIrq), 32'h0);
    storeWord(A_TCMP, 32'h7000_0000);
    storeWord(A_TCOUNT, 32'hFFFF_FFFF);
    readCheck("tcountMax", A_TCOUNT, 32'hFFFF_FFFF);
    tick();
    readCheck("tcountWrap", A_TCOUNT, 32'h0);

    // FIFO fill, overflow, held head, then push+pop on a full FIFO.
    TxReady = 1'b0;
    checkOutput("txValidIdle", 32'(TxValid), 32'h0);
    storeWord(A_TXDATA, 32'h0000_0011);
    checkOutput("txValidLatency", 32'(TxValid), 32'h1);
    checkOutput("txHeadFirst", 32'(TxData), 32'h11);
    storeWord(A_TXDATA, 32'h0000_0012);
    storeWord(A_TXDATA, 32'h0000_0013);
    storeWord(A_TXDATA, 32'h0000_0014);
    readCheck("statusFull", A_STATUS, 32'h0000_0042);
    storeWord(A_TXDATA, 32'h0000_0015);
    readCheck("statusOverflow", A_STATUS, 32'h0000_004A);
    repeat (2) tick();
    checkOutput("txHeadHeld", 32'(TxData), 32'h11);
    storeWord(A_STATUS, 32'h8);
    readCheck("overflowW1C", A_STATUS, 32'h0000_0042);

    TxReady = 1'b1;
    storeWord(A_TXDATA, 32'h0000_0099);
    TxReady = 1'b0;
    readCheck("statusPushPop", A_STATUS, 32'h0000_0042);

    drainExp[0] = 8'h12;
    drainExp[1] = 8'h13;
    drainExp[2] = 8'h14;
    drainExp[3] = 8'h99;
    TxReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drainValid%0d", i), 32'(TxValid), 32'h1);
      checkOutput($sformatf("drainData%0d", i), 32'(TxData), 32'(drainExp[i]));
      tick();
    end
    TxReady = 1'b0;
    checkOutput("drainedValid", 32'(TxValid), 32'h0);
    checkOutput("drainedData", 32'(TxData), 32'h0);
    readCheck("statusDrained", A_STATUS, 32'h0000_0004);

    // Reset while bytes are queued discards them.
    storeWord(A_TXDATA, 32'h0000_0021);
    storeWord(A_TXDATA, 32'h0000_0022);
    storeWord(A_TXDATA, 32'h0000_0023);
    readCheck("statusThree", A_STATUS, 32'h0000_0030);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("txValidAfterReset", 32'(TxValid), 32'h0);
    readCheck("statusAfterReset", A_STATUS, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
